// File: rtl/ppu_fb_swap.sv
// Double-buffered PPU frame buffer with vblank-synchronised bank swap and scaled, centred VGA read-out.
// Optional FB_DROP_CNT_EN: implements the 16-bit saturating dropped-frame counter (tied to 0 otherwise).
module ppu_fb_swap #(
  parameter int unsigned       PIX_W      = 8,
  parameter int unsigned       COLS       = 256,
  parameter int unsigned       ROWS       = 240,
  parameter int unsigned       SCALE_LOG2 = 1,
  parameter int unsigned       H_OFF      = 64,
  parameter int unsigned       V_OFF      = 0,
  parameter logic [PIX_W-1:0]  BORDER     = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [8:0]       wr_row,
  input  logic [8:0]       wr_col,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             wr_en,
  input  logic             wr_frame_done,
  output logic             back_free,
  input  logic [9:0]       rd_row,
  input  logic [9:0]       rd_col,
  output logic [PIX_W-1:0] rd_data,
  input  logic             vblank,
  output logic             front_sel,
  output logic             swap_pending,
  output logic [15:0]      drop_cnt
);

  localparam int unsigned DEPTH = ROWS * COLS;
  localparam int unsigned AW    = $clog2(2 * DEPTH);

  localparam logic [9:0]    ROWS_L  = 10'(ROWS);
  localparam logic [9:0]    COLS_L  = 10'(COLS);
  localparam logic [9:0]    H_OFF_L = 10'(H_OFF);
  localparam logic [9:0]    V_OFF_L = 10'(V_OFF);
  localparam logic [AW-1:0] BANK1   = AW'(DEPTH);
  localparam logic [AW-1:0] COLS_A  = AW'(COLS);

  typedef enum logic {
    ST_FILL,
    ST_PENDING
  } state_t;

  state_t state;
  logic   vblank_q;
  logic   vb_rise;

  assign vb_rise = vblank && !vblank_q;

  // Swap control: a frame_done coinciding with the vblank edge swaps at once instead of pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_FILL;
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
      back_free    <= 1'b1;
      vblank_q     <= 1'b0;
    end else begin
      vblank_q <= vblank;
      case (state)
        ST_FILL: begin
          if (wr_frame_done && vb_rise) begin
            front_sel <= ~front_sel;
          end else if (wr_frame_done) begin
            state        <= ST_PENDING;
            swap_pending <= 1'b1;
            back_free    <= 1'b0;
          end
        end
        ST_PENDING: begin
          if (vb_rise) begin
            state        <= ST_FILL;
            front_sel    <= ~front_sel;
            swap_pending <= 1'b0;
            back_free    <= 1'b1;
          end
        end
        default: begin
          state        <= ST_FILL;
          swap_pending <= 1'b0;
          back_free    <= 1'b1;
        end
      endcase
    end
  end

`ifdef FB_DROP_CNT_EN
  logic [15:0] drop_q;
  logic        drop_evt;

  assign drop_evt = wr_frame_done && (state == ST_PENDING);

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
    end else if (drop_evt && (drop_q != '1)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif

  // Both banks live in one array; bank 1 occupies the upper DEPTH words.
  logic [PIX_W-1:0] mem [0:2*DEPTH-1];

  logic          wr_ok;
  logic [AW-1:0] wr_idx;

  assign wr_ok  = wr_en && back_free &&
                  ({1'b0, wr_row} < ROWS_L) && ({1'b0, wr_col} < COLS_L);
  assign wr_idx = (front_sel ? '0 : BANK1) + AW'(wr_row) * COLS_A + AW'(wr_col);

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_idx] <= wr_data;
    end
  end

  logic [9:0]    row_rel;
  logic [9:0]    col_rel;
  logic [9:0]    sr;
  logic [9:0]    sc;
  logic          rd_inside_c;
  logic [AW-1:0] rd_idx_c;

  assign row_rel     = rd_row - V_OFF_L;
  assign col_rel     = rd_col - H_OFF_L;
  assign sr          = row_rel >> SCALE_LOG2;
  assign sc          = col_rel >> SCALE_LOG2;
  assign rd_inside_c = (rd_row >= V_OFF_L) && (rd_col >= H_OFF_L) &&
                       (sr < ROWS_L) && (sc < COLS_L);
  // Bank is folded into the stage-1 index so a swap never splits a pixel; outside reads park in range.
  assign rd_idx_c    = (front_sel ? BANK1 : '0) +
                       (rd_inside_c ? (AW'(sr) * COLS_A + AW'(sc)) : '0);

  logic          rd_inside_q;
  logic [AW-1:0] rd_idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_inside_q <= 1'b0;
      rd_idx_q    <= '0;
      rd_data     <= '0;
    end else begin
      rd_inside_q <= rd_inside_c;
      rd_idx_q    <= rd_idx_c;
      rd_data     <= rd_inside_q ? mem[rd_idx_q] : BORDER;
    end
  end

endmodule

// File: tb/tb_ppu_fb_swap.sv
// Directed self-checking bench for ppu_fb_swap (default parameters).
module tb_ppu_fb_swap;

`ifdef FB_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  wr_row;
  logic [8:0]  wr_col;
  logic [7:0]  wr_data;
  logic        wr_en;
  logic        wr_frame_done;
  logic        back_free;
  logic [9:0]  rd_row;
  logic [9:0]  rd_col;
  logic [7:0]  rd_data;
  logic        vblank;
  logic        front_sel;
  logic        swap_pending;
  logic [15:0] drop_cnt;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  ppu_fb_swap dut (
    .clk           (clk),
    .rst           (rst),
    .wr_row        (wr_row),
    .wr_col        (wr_col),
    .wr_data       (wr_data),
    .wr_en         (wr_en),
    .wr_frame_done (wr_frame_done),
    .back_free     (back_free),
    .rd_row        (rd_row),
    .rd_col        (rd_col),
    .rd_data       (rd_data),
    .vblank        (vblank),
    .front_sel     (front_sel),
    .swap_pending  (swap_pending),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_px(input logic [8:0] r, input logic [8:0] c, input logic [7:0] d);
    wr_row = r; wr_col = c; wr_data = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_done();
    wr_frame_done = 1'b1;
    tick();
    wr_frame_done = 1'b0;
  endtask

  task automatic read_px(input logic [9:0] r, input logic [9:0] c);
    rd_row = r; rd_col = c;
    tick();
    tick();
  endtask

  task automatic test_reset();
    read_px(10'd0, 10'd0);
    n_checks++; if (rd_data !== 8'h00) $display("FAIL reset_rd_data got=%h exp=00", rd_data); else n_pass++;
    n_checks++; if (front_sel !== 1'b0) $display("FAIL reset_front_sel got=%b exp=0", front_sel); else n_pass++;
    n_checks++; if (back_free !== 1'b1) $display("FAIL reset_back_free got=%b exp=1", back_free); else n_pass++;
    n_checks++; if (swap_pending !== 1'b0) $display("FAIL reset_pending got=%b exp=0", swap_pending); else n_pass++;
    n_checks++; if (drop_cnt !== 16'd0) $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt); else n_pass++;
  endtask

  task automatic test_swap();
    write_px(9'd5, 9'd7, 8'h2A);
    pulse_done();
    n_checks++; if (swap_pending !== 1'b1) $display("FAIL swap_pending_set got=%b exp=1", swap_pending); else n_pass++;
    n_checks++; if (back_free !== 1'b0) $display("FAIL swap_back_free_clr got=%b exp=0", back_free); else n_pass++;
    vblank = 1'b1;
    tick();
    n_checks++; if (front_sel !== 1'b1) $display("FAIL swap_front_sel got=%b exp=1", front_sel); else n_pass++;
    n_checks++; if (swap_pending !== 1'b0) $display("FAIL swap_pending_clr got=%b exp=0", swap_pending); else n_pass++;
    n_checks++; if (back_free !== 1'b1) $display("FAIL swap_back_free_set got=%b exp=1", back_free); else n_pass++;
    vblank = 1'b0;
    tick();
    read_px(10'd10, 10'd63);
    n_checks++; if (rd_data !== 8'h00) $display("FAIL rd_left_border got=%h exp=00", rd_data); else n_pass++;
    rd_col = 10'd78;
    tick();
    n_checks++; if (rd_data !== 8'h00) $display("FAIL rd_latency_1cyc got=%h exp=00", rd_data); else n_pass++;
    tick();
    n_checks++; if (rd_data !== 8'h2A) $display("FAIL rd_78 got=%h exp=2a", rd_data); else n_pass++;
    read_px(10'd10, 10'd79);
    n_checks++; if (rd_data !== 8'h2A) $display("FAIL rd_79 got=%h exp=2a", rd_data); else n_pass++;
    read_px(10'd10, 10'd576);
    n_checks++; if (rd_data !== 8'h00) $display("FAIL rd_right_border got=%h exp=00", rd_data); else n_pass++;
    read_px(10'd480, 10'd78);
    n_checks++; if (rd_data !== 8'h00) $display("FAIL rd_bottom_border got=%h exp=00", rd_data); else n_pass++;
  endtask

  task automatic test_drop();
    write_px(9'd5, 9'd7, 8'h55);
    pulse_done();
    pulse_done();
    pulse_done();
    n_checks++; if (swap_pending !== 1'b1) $display("FAIL drop_pending got=%b exp=1", swap_pending); else n_pass++;
    n_checks++; if (drop_cnt !== (DROP_EN ? 16'd2 : 16'd0)) $display("FAIL drop_cnt got=%0d exp=%0d", drop_cnt, DROP_EN ? 2 : 0); else n_pass++;
    write_px(9'd5, 9'd7, 8'h99);
    n_checks++; if (front_sel !== 1'b1) $display("FAIL drop_no_swap got=%b exp=1", front_sel); else n_pass++;
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
    n_checks++; if (front_sel !== 1'b0) $display("FAIL drop_swap got=%b exp=0", front_sel); else n_pass++;
    read_px(10'd10, 10'd78);
    n_checks++; if (rd_data !== 8'h55) $display("FAIL drop_blocked_write got=%h exp=55", rd_data); else n_pass++;
  endtask

  task automatic test_simultaneous();
    vblank = 1'b1;
    wr_frame_done = 1'b1;
    tick();
    wr_frame_done = 1'b0;
    n_checks++; if (front_sel !== 1'b1) $display("FAIL simul_front_sel got=%b exp=1", front_sel); else n_pass++;
    n_checks++; if (swap_pending !== 1'b0) $display("FAIL simul_pending got=%b exp=0", swap_pending); else n_pass++;
    n_checks++; if (back_free !== 1'b1) $display("FAIL simul_back_free got=%b exp=1", back_free); else n_pass++;
    vblank = 1'b0;
    tick();
    pulse_done();
    vblank = 1'b1;
    wr_frame_done = 1'b1;
    tick();
    wr_frame_done = 1'b0;
    vblank = 1'b0;
    n_checks++; if (front_sel !== 1'b0) $display("FAIL simul_drop_front got=%b exp=0", front_sel); else n_pass++;
    n_checks++; if (swap_pending !== 1'b0) $display("FAIL simul_drop_pending got=%b exp=0", swap_pending); else n_pass++;
    n_checks++; if (drop_cnt !== (DROP_EN ? 16'd3 : 16'd0)) $display("FAIL simul_drop_cnt got=%0d exp=%0d", drop_cnt, DROP_EN ? 3 : 0); else n_pass++;
    tick();
  endtask

  task automatic test_vblank_hold();
    int unsigned toggles = 0;
    logic        prev;
    pulse_done();
    vblank = 1'b1;
    prev = front_sel;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (front_sel !== prev) toggles++;
      prev = front_sel;
    end
    n_checks++; if (toggles !== 1) $display("FAIL hold_toggles got=%0d exp=1", toggles); else n_pass++;
    n_checks++; if (front_sel !== 1'b1) $display("FAIL hold_front_sel got=%b exp=1", front_sel); else n_pass++;
    vblank = 1'b0;
    tick();
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
    n_checks++; if (front_sel !== 1'b1) $display("FAIL edge_no_pending got=%b exp=1", front_sel); else n_pass++;
    tick();
  endtask

  task automatic test_reset_pending();
    pulse_done();
    n_checks++; if (swap_pending !== 1'b1) $display("FAIL rstp_pending_set got=%b exp=1", swap_pending); else n_pass++;
    rst = 1'b1;
    vblank = 1'b1;
    wr_frame_done = 1'b1;
    tick();
    rst = 1'b0;
    wr_frame_done = 1'b0;
    n_checks++; if (swap_pending !== 1'b0) $display("FAIL rstp_pending got=%b exp=0", swap_pending); else n_pass++;
    n_checks++; if (front_sel !== 1'b0) $display("FAIL rstp_front_sel got=%b exp=0", front_sel); else n_pass++;
    n_checks++; if (back_free !== 1'b1) $display("FAIL rstp_back_free got=%b exp=1", back_free); else n_pass++;
    n_checks++; if (drop_cnt !== 16'd0) $display("FAIL rstp_drop_cnt got=%0d exp=0", drop_cnt); else n_pass++;
    n_checks++; if (rd_data !== 8'h00) $display("FAIL rstp_rd_data got=%h exp=00", rd_data); else n_pass++;
    vblank = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; wr_row = '0; wr_col = '0; wr_data = '0; wr_en = 1'b0;
    wr_frame_done = 1'b0; rd_row = '0; rd_col = '0; vblank = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;
    test_reset();
    test_swap();
    test_drop();
    test_simultaneous();
    test_vblank_hold();
    test_reset_pending();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ppu_fb_swap.md
# ppu_fb_swap

Parametrised double-buffered frame buffer between the PPU pixel writer and the VGA scan-out controller. The PPU renders into the back bank while the VGA controller reads the front bank; banks swap only on the VGA's vertical-blank indication, so scan-out never tears. The source frame is scaled by a power of two and centred in the VGA raster, with a border colour outside it. It replaces the single-bank VGA buffer and adds swap handshaking plus frame-drop accounting.

## Interface
Parameters:
- PIX_W, 8, pixel/palette index width
- COLS, 256, source frame width (pixels)
- ROWS, 240, source frame height (lines)
- SCALE_LOG2, 1, scale factor = 2^SCALE_LOG2 in both axes
- H_OFF, 64, first VGA column of the scaled image
- V_OFF, 0, first VGA row of the scaled image
- BORDER, 0, PIX_W-bit value output outside the scaled image

Ports:
- clk  in  1  single clock (25 MHz pixel clock)
- rst  in  1  synchronous, active-high reset
- wr_row  in  9  PPU source row
- wr_col  in  9  PPU source column
- wr_data  in  PIX_W  PPU pixel
- wr_en  in  1  write strobe
- wr_frame_done  in  1  one-cycle pulse: back bank holds a complete frame
- back_free  out  1  back bank may be written (PPU start permission)
- rd_row  in  10  VGA raster row
- rd_col  in  10  VGA raster column
- rd_data  out  PIX_W  pixel for (rd_row, rd_col), 2-cycle latency
- vblank  in  1  VGA vertical blank / done level
- front_sel  out  1  bank currently scanned out
- swap_pending  out  1  finished frame waiting for vblank
- drop_cnt  out  16  frames discarded (macro-dependent, see Configuration)

## Operation
- Two banks of ROWS*COLS words; bank address = row*COLS + col. Contents are not cleared by reset.
- Write path: when wr_en=1, back_free=1, wr_row<ROWS and wr_col<COLS, write wr_data to bank !front_sel. Otherwise the write is ignored.
- wr_frame_done with swap_pending=0 sets swap_pending=1 and clears back_free.
- wr_frame_done with swap_pending=1 drops the frame: pending is unchanged and drop_cnt increments, saturating at 0xFFFF.
- Swap: on a vblank rising edge (registered vblank 0 -> 1) with swap_pending=1, toggle front_sel, clear swap_pending and set back_free.
- Simultaneous rising edge and wr_frame_done:
  - with pending=0: swap immediately; pending never asserts; back_free stays 1.
  - with pending=1: swap, and count the frame_done as a drop.
- A vblank edge without pending does nothing. A vblank held high does not retrigger.
- Read path, stage 1 (registered):
  - sr = (rd_row - V_OFF) >> SCALE_LOG2; sc = (rd_col - H_OFF) >> SCALE_LOG2, in 10-bit unsigned arithmetic.
  - inside = rd_row>=V_OFF && rd_col>=H_OFF && sr<ROWS && sc<COLS.
  - Latch front_sel together with the address.
- Read path, stage 2: synchronous RAM read; rd_data = inside ? word : BORDER.
- Reset values: front_sel=0, swap_pending=0, back_free=1, drop_cnt=0, rd_data=0, pipeline inside flags=0, vblank edge register=0. Reset during pending cancels the swap; reset has priority over all events in the same cycle.

## Timing
- Write: RAM updated at the clk edge sampling wr_en; readable by the VGA port only after a swap.
- back_free drops the cycle after wr_frame_done and rises the cycle after the swap edge.
- front_sel toggles the cycle after vblank is sampled 0 then 1 (1-cycle edge detect).
- rd_data reflects rd_row/rd_col presented 2 cycles earlier. A bank swap is never visible mid-pixel, because the bank is latched in stage 1.
- Throughput: one write and one read per cycle, independent ports.

## Configuration
- FB_DROP_CNT_EN defined: drop_cnt is implemented as described (16-bit saturating, cleared only by rst).
- Undefined: no counter register; drop_cnt is tied to 0. Drop behaviour (pending unchanged) is identical.

## Test plan
- Reset, then read (rd_row=0, rd_col=0) -> rd_data=BORDER=0 two cycles later; front_sel=0, back_free=1, drop_cnt=0.
- Write 0x2A at (5,7), pulse wr_frame_done, raise vblank:
  - front_sel=1 one cycle after the edge.
  - Read rd_row=10, rd_col=78 -> 0x2A after 2 cycles; rd_col=79 -> 0x2A; rd_col=63 -> BORDER.
- Pulse wr_frame_done three times with no vblank -> swap_pending=1, drop_cnt=2. A write while back_free=0 leaves memory unchanged after the swap.
- wr_frame_done in the same cycle as the vblank rising edge, with pending=0 -> front_sel toggles, swap_pending stays 0, back_free stays 1.
- Hold vblank high 100 cycles with pending set once -> exactly one toggle. Assert rst while pending -> pending=0, front_sel=0.
- Build without FB_DROP_CNT_EN and repeat the drop test -> drop_cnt=0, swap behaviour identical.
